icache_ctrl: RTL

//  Responder side of the fetch<->i-cache read protocol. Direct-mapped, blocking i-cache controller.

---
 rtl/mmm_pkg.sv | 26 ++
 rtl/icache_array.sv | 52 +++++
 rtl/icache_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mmm_pkg.sv
// Shared fetch/i-cache types and geometry for the instruction-side memory path.
package mmm_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned ICACHE_OFFSET   = 4;
  localparam int unsigned ICACHE_LINE_LEN = 8 * (1 << ICACHE_OFFSET);
  localparam int unsigned ICACHE_SETS     = 16;

  typedef struct packed {
    logic [XLEN-1:0]            pc;
    logic [ICACHE_LINE_LEN-1:0] line;
  } icache_out_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT
  } icache_ctrl_state_t;

  // Clear the byte-offset bits so the address names the start of its line.
  function automatic logic [XLEN-1:0] line_align(input logic [XLEN-1:0] addr);
    line_align = {addr[XLEN-1:ICACHE_OFFSET], {ICACHE_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped i-cache storage: valid bits (reset), tag and data arrays (not reset).
import mmm_pkg::*;

module icache_array #(
  parameter int unsigned NUM_SETS = ICACHE_SETS,
  parameter int unsigned IDX_W    = $clog2(NUM_SETS),
  parameter int unsigned TAG_W    = XLEN - ICACHE_OFFSET - IDX_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic                       rd_valid,
  output logic [TAG_W-1:0]           rd_tag,
  output logic [ICACHE_LINE_LEN-1:0] rd_line,
  input  logic                       we,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [TAG_W-1:0]           wr_tag,
  input  logic [ICACHE_LINE_LEN-1:0] wr_line,
  input  logic                       invalidate_all
);

  logic [NUM_SETS-1:0]        valid_q;
  logic [TAG_W-1:0]           tag_q  [NUM_SETS];
  logic [ICACHE_LINE_LEN-1:0] data_q [NUM_SETS];

  // Valid bits: a global invalidate takes priority over a same-cycle refill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (invalidate_all) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and line storage, written on refill only.
  always_ff @(posedge clk_i) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  // Combinational read port.
  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_line  = data_q[rd_idx];
  end

endmodule

// File: rtl/icache_ctrl.sv
// Blocking direct-mapped i-cache controller answering fetch line reads and
// refilling misses through a valid/ready memory request channel.
import mmm_pkg::*;

module icache_ctrl #(
  parameter int unsigned NUM_SETS = ICACHE_SETS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       invalidate_i,
  input  logic                       read_req_i,
  input  logic [XLEN-1:0]            pc_i,
  output logic                       read_done_o,
  output icache_out_t                cache_out_o,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [XLEN-1:0]            mem_req_addr_o,
  input  logic                       mem_resp_valid_i,
  input  logic [ICACHE_LINE_LEN-1:0] mem_resp_data_i
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = XLEN - ICACHE_OFFSET - IDX_W;

  icache_ctrl_state_t         state_q;
  logic                       abort_q;
  logic [XLEN-1:0]            addr_q;

  logic [IDX_W-1:0]           idx;
  logic [TAG_W-1:0]           tag;
  logic                       rd_valid;
  logic [TAG_W-1:0]           rd_tag;
  logic [ICACHE_LINE_LEN-1:0] rd_line;
  logic                       hit;
  logic                       refill_we;

  // Lookup/refill address fields and hit/write decode from the latched request.
  always_comb begin
    idx       = addr_q[ICACHE_OFFSET +: IDX_W];
    tag       = addr_q[XLEN-1 -: TAG_W];
    hit       = rd_valid && (rd_tag == tag);
    refill_we = (state_q == MISS_WAIT) && mem_resp_valid_i;
  end

  icache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rd_idx         (idx),
    .rd_valid       (rd_valid),
    .rd_tag         (rd_tag),
    .rd_line        (rd_line),
    .we             (refill_we),
    .wr_idx         (idx),
    .wr_tag         (tag),
    .wr_line        (mem_resp_data_i),
    .invalidate_all (invalidate_i)
  );

  // Request FSM with registered responses. A flush during a refill only
  // marks the request aborted: the memory handshake and array write still
  // complete so the memory side never sees a dropped request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      abort_q         <= 1'b0;
      addr_q          <= '0;
      read_done_o     <= 1'b0;
      cache_out_o     <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
    end else begin
      read_done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (read_req_i && !flush_i && !read_done_o) begin
            addr_q  <= pc_i;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else if (hit) begin
            read_done_o      <= 1'b1;
            cache_out_o.pc   <= addr_q;
            cache_out_o.line <= rd_line;
            state_q          <= IDLE;
          end else begin
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= line_align(addr_q);
            state_q         <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (flush_i) begin
            abort_q <= 1'b1;
          end
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state_q         <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (mem_resp_valid_i) begin
            if (!abort_q && !flush_i) begin
              read_done_o      <= 1'b1;
              cache_out_o.pc   <= addr_q;
              cache_out_o.line <= mem_resp_data_i;
            end
            abort_q <= 1'b0;
            state_q <= IDLE;
          end else if (flush_i) begin
            abort_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
